// File: rtl/riscv_apu_pkg.sv
// riscv_apu_pkg: shared latency-class encoding for the APU dispatcher.
package riscv_apu_pkg;
    typedef enum logic [1:0] {LAT_1 = 2'd1, LAT_2 = 2'd2, LAT_MULTI = 2'd3} apu_lat_e;
endpackage

// File: rtl/riscv_apu_disp_tracker.sv
// riscv_apu_disp_tracker: in-order circular buffer of destination registers for outstanding APU ops.
module riscv_apu_disp_tracker #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [ADDR_W-1:0]            push_addr_i,
    output logic [ADDR_W-1:0]            head_addr_o,
    output logic [DEPTH*ADDR_W-1:0]      addrs_o,
    output logic [DEPTH-1:0]             valid_o,
    output logic [$clog2(DEPTH)-1:0]     head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];

    // DEPTH is a power of 2, so pointer wrap is the natural PW-bit overflow
    always_comb begin
        head_d  = head_q + PW'(pop_i);
        tail_d  = tail_q + PW'(push_i);
        count_d = count_q + CW'(push_i) - CW'(pop_i);
        valid_d = valid_q;
        addr_d  = addr_q;
        if (pop_i) valid_d[head_q] = 1'b0;
        if (push_i) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = push_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            addr_q  <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        addrs_o = '0;
        for (int i = 0; i < DEPTH; i++) addrs_o[i*ADDR_W +: ADDR_W] = addr_q[i];
    end

    assign head_addr_o = addr_q[head_q];
    assign valid_o     = valid_q;
    assign head_o      = head_q;
    assign count_o     = count_q;
endmodule

// File: rtl/riscv_apu_disp_multi.sv
// riscv_apu_disp_multi: APU request dispatcher tracking up to DEPTH in-order outstanding ops,
// with hazard detection and ID-stage stall/perf generation.
module riscv_apu_disp_multi
    import riscv_apu_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4,
    parameter int N_RD   = 3,
    parameter int N_WR   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [1:0]                   apu_lat_i,
    input  logic [ADDR_W-1:0]            apu_waddr_i,
    output logic [ADDR_W-1:0]            apu_waddr_o,
    output logic                         apu_multicycle_o,
    output logic                         apu_singlecycle_o,
    output logic                         active_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic                         stall_o,
    input  logic [N_RD*ADDR_W-1:0]       read_regs_i,
    input  logic [N_RD-1:0]              read_regs_valid_i,
    output logic                         read_dep_o,
    input  logic [N_WR*ADDR_W-1:0]       write_regs_i,
    input  logic [N_WR-1:0]              write_regs_valid_i,
    output logic                         write_dep_o,
    output logic                         perf_type_o,
    output logic                         perf_cont_o,
    output logic                         spurious_o,
    output logic                         apu_master_req_o,
    output logic                         apu_master_ready_o,
    input  logic                         apu_master_gnt_i,
    input  logic                         apu_master_valid_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [1:0]              lat_q, lat_d;
    logic                    spurious_q, spurious_d;
    logic [ADDR_W-1:0]       head_addr;
    logic [DEPTH*ADDR_W-1:0] addrs;
    logic [DEPTH-1:0]        valid_vec;
    logic [PW-1:0]           head;
    logic [CW-1:0]           count;
    logic empty, stall_full, stall_type, stall_nack, valid_req, returned_req, push, pop, push_cand;

    assign empty        = count == '0;
    assign stall_full   = count == CW'(DEPTH);
    // an op may only trail in-flight work if it cannot overtake it
    assign stall_type   = enable_i & ~empty & (apu_lat_i == LAT_1 | apu_lat_i == LAT_MULTI |
                          (apu_lat_i == LAT_2 & lat_q == LAT_MULTI));
    assign valid_req    = enable_i & ~stall_full & ~stall_type;
    assign stall_nack   = valid_req & ~apu_master_gnt_i;
    assign returned_req = valid_req & apu_master_valid_i & empty;
    assign pop          = apu_master_valid_i & ~empty;
    assign push_cand    = valid_req & ~returned_req;
    assign push         = push_cand & apu_master_gnt_i;

    riscv_apu_disp_tracker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_tracker (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .pop_i       (pop),
        .push_addr_i (apu_waddr_i),
        .head_addr_o (head_addr),
        .addrs_o     (addrs),
        .valid_o     (valid_vec),
        .head_o      (head),
        .count_o     (count)
    );

    always_comb begin
        lat_d       = valid_req ? apu_lat_i : lat_q;
        spurious_d  = spurious_q | (apu_master_valid_i & empty & ~valid_req);
        read_dep_o  = 1'b0;
        write_dep_o = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (valid_vec[e] && !(pop && head == PW'(e))) begin
                for (int p = 0; p < N_RD; p++)
                    read_dep_o = read_dep_o | (read_regs_valid_i[p] &
                                 (read_regs_i[p*ADDR_W +: ADDR_W] == addrs[e*ADDR_W +: ADDR_W]));
                for (int p = 0; p < N_WR; p++)
                    write_dep_o = write_dep_o | (write_regs_valid_i[p] &
                                  (write_regs_i[p*ADDR_W +: ADDR_W] == addrs[e*ADDR_W +: ADDR_W]));
            end
        end
        if (push_cand) begin
            for (int p = 0; p < N_RD; p++)
                read_dep_o = read_dep_o | (read_regs_valid_i[p] & (read_regs_i[p*ADDR_W +: ADDR_W] == apu_waddr_i));
            for (int p = 0; p < N_WR; p++)
                write_dep_o = write_dep_o | (write_regs_valid_i[p] & (write_regs_i[p*ADDR_W +: ADDR_W] == apu_waddr_i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            lat_q      <= lat_d;
            spurious_q <= spurious_d;
        end
    end

    assign apu_waddr_o        = returned_req ? apu_waddr_i : head_addr;
    assign apu_multicycle_o   = lat_q == LAT_MULTI;
    assign apu_singlecycle_o  = empty;
    assign active_o           = ~empty;
    assign occupancy_o        = count;
    assign stall_o            = stall_full | stall_type | stall_nack;
    assign perf_type_o        = stall_type;
    assign perf_cont_o        = stall_nack;
    assign spurious_o         = spurious_q;
    assign apu_master_req_o   = valid_req;
    assign apu_master_ready_o = 1'b1;
endmodule

// File: tb/tb_riscv_apu_disp_multi.sv
// tb_riscv_apu_disp_multi: directed scenarios plus randomized traffic against a queue-based model.
module tb_riscv_apu_disp_multi;
    localparam int AW = 6;
    localparam int D  = 4;
    localparam int NR = 3;
    localparam int NW = 2;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic enable_i = 1'b0;
    logic [1:0] apu_lat_i = 2'd0;
    logic [AW-1:0] apu_waddr_i = '0;
    logic [AW-1:0] apu_waddr_o;
    logic apu_multicycle_o, apu_singlecycle_o, active_o, stall_o;
    logic [2:0] occupancy_o;
    logic [NR*AW-1:0] read_regs_i = '0;
    logic [NR-1:0] read_regs_valid_i = '0;
    logic read_dep_o;
    logic [NW*AW-1:0] write_regs_i = '0;
    logic [NW-1:0] write_regs_valid_i = '0;
    logic write_dep_o, perf_type_o, perf_cont_o, spurious_o;
    logic apu_master_req_o, apu_master_ready_o;
    logic apu_master_gnt_i = 1'b1;
    logic apu_master_valid_i = 1'b0;

    always #5 clk_i = ~clk_i;

    riscv_apu_disp_multi #(.ADDR_W(AW), .DEPTH(D), .N_RD(NR), .N_WR(NW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .apu_lat_i(apu_lat_i),
        .apu_waddr_i(apu_waddr_i), .apu_waddr_o(apu_waddr_o), .apu_multicycle_o(apu_multicycle_o),
        .apu_singlecycle_o(apu_singlecycle_o), .active_o(active_o), .occupancy_o(occupancy_o),
        .stall_o(stall_o), .read_regs_i(read_regs_i), .read_regs_valid_i(read_regs_valid_i),
        .read_dep_o(read_dep_o), .write_regs_i(write_regs_i), .write_regs_valid_i(write_regs_valid_i),
        .write_dep_o(write_dep_o), .perf_type_o(perf_type_o), .perf_cont_o(perf_cont_o),
        .spurious_o(spurious_o), .apu_master_req_o(apu_master_req_o),
        .apu_master_ready_o(apu_master_ready_o), .apu_master_gnt_i(apu_master_gnt_i),
        .apu_master_valid_i(apu_master_valid_i)
    );

    int checks = 0;
    int errors = 0;

    int q[$];
    logic [1:0] m_lat;
    logic m_spur;
    logic e_req, e_type, e_nack, e_full, e_stall, e_ret, e_rdep, e_wdep;

    function automatic void model_eval();
        bit empty;
        empty  = q.size() == 0;
        e_full = q.size() == D;
        e_type = enable_i && !empty && (apu_lat_i == 1 || apu_lat_i == 3 || (apu_lat_i == 2 && m_lat == 3));
        e_req  = enable_i && !e_full && !e_type;
        e_nack = e_req && !apu_master_gnt_i;
        e_stall = e_full || e_type || e_nack;
        e_ret  = e_req && apu_master_valid_i && empty;
        e_rdep = 1'b0;
        e_wdep = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (i == 0 && apu_master_valid_i) continue;
            for (int p = 0; p < NR; p++) if (read_regs_valid_i[p] && read_regs_i[p*AW +: AW] == q[i]) e_rdep = 1'b1;
            for (int p = 0; p < NW; p++) if (write_regs_valid_i[p] && write_regs_i[p*AW +: AW] == q[i]) e_wdep = 1'b1;
        end
        if (e_req && !e_ret) begin
            for (int p = 0; p < NR; p++) if (read_regs_valid_i[p] && read_regs_i[p*AW +: AW] == apu_waddr_i) e_rdep = 1'b1;
            for (int p = 0; p < NW; p++) if (write_regs_valid_i[p] && write_regs_i[p*AW +: AW] == apu_waddr_i) e_wdep = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_lat  = 2'd0;
        m_spur = 1'b0;
    endfunction

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic tick();
        bit empty;
        model_eval();
        empty = q.size() == 0;
        @(posedge clk_i);
        if (e_req) m_lat = apu_lat_i;
        if (apu_master_valid_i && empty && !e_req) m_spur = 1'b1;
        if (!e_ret) begin
            if (apu_master_valid_i && !empty) void'(q.pop_front());
            if (e_req && apu_master_gnt_i) q.push_back(int'(apu_waddr_i));
        end
        @(negedge clk_i);
    endtask

    task automatic idle();
        enable_i = 1'b0; apu_lat_i = 2'd0; apu_waddr_i = '0;
        apu_master_gnt_i = 1'b1; apu_master_valid_i = 1'b0;
        read_regs_valid_i = '0; write_regs_valid_i = '0;
    endtask

    task automatic issue(input logic [1:0] lat, input int addr);
        idle();
        enable_i = 1'b1; apu_lat_i = lat; apu_waddr_i = AW'(addr);
        tick();
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++;
        if (stall_o !== 1'b0 || active_o !== 1'b0 || apu_singlecycle_o !== 1'b1 || apu_waddr_o !== '0 ||
            occupancy_o !== 3'd0 || spurious_o !== 1'b0 || apu_master_req_o !== 1'b0 || apu_master_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset: stall=%b active=%b single=%b waddr=%0d occ=%0d spur=%b req=%b ready=%b, required 0 0 1 0 0 0 0 1",
                     stall_o, active_o, apu_singlecycle_o, apu_waddr_o, occupancy_o, spurious_o, apu_master_req_o, apu_master_ready_o);
        end
    endtask

    task automatic test_single_cycle();
        idle();
        enable_i = 1'b1; apu_lat_i = 2'd1; apu_waddr_i = 6'd5; apu_master_valid_i = 1'b1;
        settle();
        checks++;
        if (apu_waddr_o !== 6'd5 || apu_master_req_o !== 1'b1) begin
            errors++;
            $display("FAIL single_cycle: waddr=%0d req=%b, required 5 1", apu_waddr_o, apu_master_req_o);
        end
        tick();
        idle();
        settle();
        checks++;
        if (occupancy_o !== 3'd0 || spurious_o !== 1'b0) begin
            errors++;
            $display("FAIL single_occ: occ=%0d spur=%b, required 0 0", occupancy_o, spurious_o);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) issue(2'd2, 10 + i);
        enable_i = 1'b1; apu_lat_i = 2'd2; apu_waddr_i = 6'd20;
        settle();
        checks++;
        if (occupancy_o !== 3'(D) || stall_o !== 1'b1 || apu_master_req_o !== 1'b0) begin
            errors++;
            $display("FAIL fill: occ=%0d stall=%b req=%b, required %0d 1 0", occupancy_o, stall_o, apu_master_req_o, D);
        end
        apu_master_valid_i = 1'b1;
        settle();
        checks++;
        if (stall_o !== 1'b1 || apu_master_req_o !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_no_release: stall=%b req=%b, required 1 0", stall_o, apu_master_req_o);
        end
        tick();
        idle(); apu_master_valid_i = 1'b1;
        tick();
        idle();
        enable_i = 1'b1; apu_lat_i = 2'd2; apu_waddr_i = 6'd21; apu_master_valid_i = 1'b1;
        settle();
        checks++;
        if (apu_waddr_o !== 6'(q[0]) || apu_master_req_o !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_ret: waddr=%0d req=%b, required %0d 1", apu_waddr_o, apu_master_req_o, q[0]);
        end
        tick();
        idle();
        settle();
        checks++;
        if (occupancy_o !== 3'd2 || occupancy_o !== 3'(q.size())) begin
            errors++;
            $display("FAIL pushpop_count: occ=%0d, required 2", occupancy_o);
        end
        while (q.size() > 0) begin idle(); apu_master_valid_i = 1'b1; tick(); end
        idle();
    endtask

    task automatic test_order();
        int exp[3] = '{3, 7, 9};
        for (int i = 0; i < 3; i++) issue(2'd2, exp[i]);
        for (int i = 0; i < 3; i++) begin
            idle(); apu_master_valid_i = 1'b1;
            settle();
            checks++;
            if (apu_waddr_o !== 6'(exp[i])) begin
                errors++;
                $display("FAIL order[%0d]: waddr=%0d, required %0d", i, apu_waddr_o, exp[i]);
            end
            tick();
        end
        issue(2'd2, 40);
        for (int i = 0; i < 6; i++) begin
            int exp_head;
            idle();
            enable_i = 1'b1; apu_lat_i = 2'd2; apu_waddr_i = 6'(41 + i); apu_master_valid_i = 1'b1;
            exp_head = 40 + i;
            settle();
            checks++;
            if (apu_waddr_o !== 6'(exp_head) || occupancy_o !== 3'd1) begin
                errors++;
                $display("FAIL wrap[%0d]: waddr=%0d occ=%0d, required %0d 1", i, apu_waddr_o, occupancy_o, exp_head);
            end
            tick();
        end
        idle(); apu_master_valid_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_hazard();
        issue(2'd2, 7);
        issue(2'd2, 12);
        idle();
        read_regs_i = {6'd1, 6'd7, 6'd2}; read_regs_valid_i = 3'b010;
        write_regs_i = {6'd12, 6'd33}; write_regs_valid_i = 2'b10;
        settle();
        checks++;
        if (read_dep_o !== 1'b1 || write_dep_o !== 1'b1) begin
            errors++;
            $display("FAIL hazard_hit: rdep=%b wdep=%b, required 1 1", read_dep_o, write_dep_o);
        end
        apu_master_valid_i = 1'b1;
        settle();
        checks++;
        if (read_dep_o !== 1'b0 || write_dep_o !== 1'b1) begin
            errors++;
            $display("FAIL hazard_pop: rdep=%b wdep=%b, required 0 1", read_dep_o, write_dep_o);
        end
        read_regs_valid_i = 3'b000;
        settle();
        checks++;
        if (read_dep_o !== 1'b0) begin
            errors++;
            $display("FAIL hazard_invalid_port: rdep=%b, required 0", read_dep_o);
        end
        tick();
        idle(); apu_master_valid_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_type_nack();
        issue(2'd3, 15);
        idle();
        enable_i = 1'b1; apu_lat_i = 2'd2; apu_waddr_i = 6'd16;
        settle();
        checks++;
        if (stall_o !== 1'b1 || perf_type_o !== 1'b1 || apu_master_req_o !== 1'b0 || apu_multicycle_o !== 1'b1) begin
            errors++;
            $display("FAIL type_stall: stall=%b type=%b req=%b multi=%b, required 1 1 0 1",
                     stall_o, perf_type_o, apu_master_req_o, apu_multicycle_o);
        end
        idle(); apu_master_valid_i = 1'b1;
        tick();
        idle();
        enable_i = 1'b1; apu_lat_i = 2'd1; apu_waddr_i = 6'd17; apu_master_gnt_i = 1'b0;
        settle();
        checks++;
        if (apu_master_req_o !== 1'b1 || perf_cont_o !== 1'b1 || stall_o !== 1'b1 || perf_type_o !== 1'b0) begin
            errors++;
            $display("FAIL nack: req=%b cont=%b stall=%b type=%b, required 1 1 1 0",
                     apu_master_req_o, perf_cont_o, stall_o, perf_type_o);
        end
        tick();
        idle();
        settle();
        checks++;
        if (occupancy_o !== 3'd0 || apu_multicycle_o !== 1'b0) begin
            errors++;
            $display("FAIL nack_nopush: occ=%0d multi=%b, required 0 0", occupancy_o, apu_multicycle_o);
        end
    endtask

    task automatic test_spurious_reset();
        idle(); apu_master_valid_i = 1'b1;
        tick();
        idle();
        settle();
        checks++;
        if (spurious_o !== 1'b1) begin
            errors++;
            $display("FAIL spurious: spur=%b, required 1", spurious_o);
        end
        for (int i = 0; i < 3; i++) issue(2'd2, 50 + i);
        idle();
        settle();
        rst_ni = 1'b0;
        model_reset();
        #1;
        checks++;
        if (occupancy_o !== 3'd0 || spurious_o !== 1'b0 || stall_o !== 1'b0 || active_o !== 1'b0 ||
            apu_singlecycle_o !== 1'b1 || apu_waddr_o !== '0 || apu_multicycle_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: occ=%0d spur=%b stall=%b active=%b single=%b waddr=%0d multi=%b, required 0 0 0 0 1 0 0",
                     occupancy_o, spurious_o, stall_o, active_o, apu_singlecycle_o, apu_waddr_o, apu_multicycle_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        apu_master_valid_i = 1'b1;
        tick();
        idle();
        settle();
        checks++;
        if (spurious_o !== 1'b1 || occupancy_o !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_resp: spur=%b occ=%0d, required 1 0", spurious_o, occupancy_o);
        end
        do_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            enable_i = $urandom_range(0, 3) != 0;
            apu_lat_i = 2'($urandom_range(1, 3));
            apu_waddr_i = AW'($urandom_range(0, 7));
            apu_master_gnt_i = $urandom_range(0, 3) != 0;
            apu_master_valid_i = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NR; p++) read_regs_i[p*AW +: AW] = AW'($urandom_range(0, 7));
            for (int p = 0; p < NW; p++) write_regs_i[p*AW +: AW] = AW'($urandom_range(0, 7));
            read_regs_valid_i = NR'($urandom);
            write_regs_valid_i = NW'($urandom);
            settle();
            checks++;
            if (apu_master_req_o !== e_req || stall_o !== e_stall || perf_type_o !== e_type || perf_cont_o !== e_nack ||
                read_dep_o !== e_rdep || write_dep_o !== e_wdep || occupancy_o !== 3'(q.size()) ||
                active_o !== (q.size() != 0) || apu_multicycle_o !== (m_lat == 2'd3) || spurious_o !== m_spur) begin
                errors++;
                $display("FAIL random[%0d]: req=%b stall=%b type=%b cont=%b rdep=%b wdep=%b occ=%0d active=%b multi=%b spur=%b, required %b %b %b %b %b %b %0d %b %b %b",
                         n, apu_master_req_o, stall_o, perf_type_o, perf_cont_o, read_dep_o, write_dep_o, occupancy_o,
                         active_o, apu_multicycle_o, spurious_o, e_req, e_stall, e_type, e_nack, e_rdep, e_wdep,
                         q.size(), q.size() != 0, m_lat == 2'd3, m_spur);
            end
            if (apu_master_valid_i && (q.size() > 0 || e_ret)) begin
                checks++;
                if (apu_waddr_o !== (e_ret ? apu_waddr_i : AW'(q[0]))) begin
                    errors++;
                    $display("FAIL random_waddr[%0d]: waddr=%0d, required %0d", n, apu_waddr_o, e_ret ? int'(apu_waddr_i) : q[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_cycle();
        test_fill();
        test_order();
        test_hazard();
        test_type_nack();
        test_spurious_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
